// File: rtl/ram.sv
// Single-port synchronous RAM with registered read data, clocked on the edge chosen by active_edge.
// RAM_WRITE_THROUGH_EN selects write-first read data on a write; left undefined it is read-first.

`ifndef POS_EDGE
`define POS_EDGE 1
`endif
`ifndef NEG_EDGE
`define NEG_EDGE 0
`endif

module ram #(
  parameter int addr_width  = 8,
  parameter int data_width  = 8,
  parameter int active_edge = `POS_EDGE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [addr_width-1:0] addr,
  input  logic [data_width-1:0] din,
  input  logic                  we,
  output logic [data_width-1:0] dout
);

  localparam int depth = 1 << addr_width;

  logic [data_width-1:0] mem_r [0:depth-1];
  logic [data_width-1:0] dout_r;
  logic [data_width-1:0] next_dout_s;

  // Read data captured on the active edge: old word (read-first) or incoming word (write-first).
  always_comb begin
    next_dout_s = mem_r[addr];
`ifdef RAM_WRITE_THROUGH_EN
    if (we) begin
      next_dout_s = din;
    end else begin
      next_dout_s = mem_r[addr];
    end
`else
    if (we) begin
      next_dout_s = mem_r[addr];
    end else begin
      next_dout_s = mem_r[addr];
    end
`endif
  end

  generate
    if (active_edge == `POS_EDGE) begin : g_pos
      // Memory array write; holding reset blocks the write but never clears contents.
      always_ff @(posedge clk) begin
        if (rst_n && we) begin
          mem_r[addr] <= din;
        end
      end

      // Registered read port with asynchronous clear.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout_r <= {data_width{1'b0}};
        end else begin
          dout_r <= next_dout_s;
        end
      end
    end else begin : g_neg
      // Memory array write on the falling edge; reset blocks the write only.
      always_ff @(negedge clk) begin
        if (rst_n && we) begin
          mem_r[addr] <= din;
        end
      end

      // Registered read port on the falling edge with asynchronous clear.
      always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout_r <= {data_width{1'b0}};
        end else begin
          dout_r <= next_dout_s;
        end
      end
    end
  endgenerate

  assign dout = dout_r;

endmodule

// File: tb/tb_ram.sv
// Bench for ram: rising- and falling-edge instances on a shared bus, checked against an array model.
// Expected read data follows RAM_WRITE_THROUGH_EN in the same way as the design build.

`ifndef POS_EDGE
`define POS_EDGE 1
`endif
`ifndef NEG_EDGE
`define NEG_EDGE 0
`endif

module tb_ram;

  logic       clk;
  logic       rst_n;
  logic [7:0] addr;
  logic [7:0] din;
  logic       we;
  logic [7:0] dout_p;
  logic [7:0] dout_n;

  int checks;
  int failures;

  // Reference model: one word array per instance plus written flags.
  logic [7:0] mem_p [256];
  logic [7:0] mem_n [256];
  bit         wr_p  [256];
  bit         wr_n  [256];
  logic [7:0] exp_p, exp_n;
  bit         known_p, known_n;

  ram #(.addr_width(8), .data_width(8), .active_edge(`POS_EDGE)) u_pos (
    .clk(clk), .rst_n(rst_n), .addr(addr), .din(din), .we(we), .dout(dout_p)
  );

  ram #(.addr_width(8), .data_width(8), .active_edge(`NEG_EDGE)) u_neg (
    .clk(clk), .rst_n(rst_n), .addr(addr), .din(din), .we(we), .dout(dout_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp, input bit known);
    if (known) begin
      checks++;
      assert (got === exp) else begin
        failures++;
        $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
    end
  endtask

  // One bus transaction: sampled at the next falling edge (neg instance) then next rising edge (pos instance).
  task automatic step(input logic [7:0] a, input logic [7:0] d, input logic w, input string tag);
    bit wt;
`ifdef RAM_WRITE_THROUGH_EN
    wt = 1'b1;
`else
    wt = 1'b0;
`endif
    addr = a; din = d; we = w;
    @(negedge clk);
    if (rst_n) begin
      exp_n   = (wt && w) ? d : mem_n[a];
      known_n = (wt && w) ? 1'b1 : wr_n[a];
      if (w) begin mem_n[a] = d; wr_n[a] = 1'b1; end
    end
    #1;
    check({tag, "_neg"}, dout_n, exp_n, known_n);
    check({tag, "_pos_hold"}, dout_p, exp_p, known_p);
    @(posedge clk);
    if (rst_n) begin
      exp_p   = (wt && w) ? d : mem_p[a];
      known_p = (wt && w) ? 1'b1 : wr_p[a];
      if (w) begin mem_p[a] = d; wr_p[a] = 1'b1; end
    end
    #1;
    check({tag, "_pos"}, dout_p, exp_p, known_p);
    check({tag, "_neg_hold"}, dout_n, exp_n, known_n);
  endtask

  task automatic assert_reset(input string tag);
    rst_n = 1'b0;
    exp_p = 8'd0; exp_n = 8'd0; known_p = 1'b1; known_n = 1'b1;
    #1;
    check({tag, "_pos"}, dout_p, 8'd0, 1'b1);
    check({tag, "_neg"}, dout_n, 8'd0, 1'b1);
  endtask

  initial begin
    checks = 0; failures = 0;
    for (int i = 0; i < 256; i++) begin wr_p[i] = 1'b0; wr_n[i] = 1'b0; end
    addr = 8'd0; din = 8'd0; we = 1'b0;
    assert_reset("por");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Write then read back, and reads ignoring din.
    step(8'd3, 8'd11, 1'b1, "wr3a");
    step(8'd3, 8'd11, 1'b1, "wr3b");
    step(8'd6, 8'd22, 1'b1, "wr6a");
    step(8'd6, 8'd22, 1'b1, "wr6b");
    step(8'd3, 8'd33, 1'b0, "rd3");
    step(8'd6, 8'd44, 1'b0, "rd6");
    step(8'd3, 8'd0, 1'b0, "rd3again");

    // Sequential fill and readback.
    for (int i = 1; i <= 9; i++) step(8'(i), 8'(i * 10), 1'b1, "fill");
    for (int i = 1; i <= 9; i++) step(8'(i), 8'd0, 1'b0, "readback");

    // Boundary addresses.
    step(8'd255, 8'hA5, 1'b1, "wr255");
    step(8'd0, 8'h5A, 1'b1, "wr0");
    step(8'd255, 8'd0, 1'b0, "rd255");
    step(8'd0, 8'd0, 1'b0, "rd0");

    // Reset pulse between edges preserves memory.
    step(8'd3, 8'd11, 1'b1, "prerst");
    assert_reset("rstpulse");
    rst_n = 1'b1;
    step(8'd3, 8'd0, 1'b0, "postrst");

    // Write attempted while reset held is blocked.
    assert_reset("rsthold");
    step(8'd3, 8'd99, 1'b1, "blockedwr");
    rst_n = 1'b1;
    step(8'd3, 8'd0, 1'b0, "afterblocked");

    // Same-address write/read.
    step(8'd5, 8'd7, 1'b1, "prep5");
    step(8'd5, 8'd9, 1'b1, "same5");
    step(8'd5, 8'd0, 1'b0, "reread5");

    // Randomized traffic on a small address window to force collisions.
    for (int i = 0; i < 300; i++) begin
      step(8'($urandom_range(0, 15)), 8'($urandom), 1'($urandom_range(0, 1)), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
